// File: rtl/module_display_mux.sv
// Multiplexed common-anode seven-segment driver: frame-synchronous digit update,
// BCD-to-segment decode, optional leading-zero blanking and anode scanning.
module module_display_mux #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 27000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic                  blank_lz_i,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [6:0]            seg_o,
  output logic                  frame_o
);

  localparam int unsigned DATA_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_shadow;
  logic [DATA_W-1:0]   r_active;
  logic                r_pending;
  logic                r_bound;

  logic                w_term;
  logic                w_last_idx;
  logic                w_boundary;
  logic [3:0]          w_nib;
  logic [N_DIGITS-1:0] w_lz;
  logic [N_DIGITS-1:0] w_onehot;
  logic                w_blank;
  logic [N_DIGITS-1:0] w_an;
  logic [6:0]          w_seg;

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD nibbles render as a dash
  function automatic logic [6:0] decode_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
    return seg;
  endfunction

  assign w_term     = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_last_idx = (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_boundary = w_term && w_last_idx;

  // Refresh counter and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_term) begin
      r_cnt <= '0;
      r_idx <= w_last_idx ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Loads park in the shadow and only reach the active digits at a frame boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
      r_bound   <= 1'b0;
    end else begin
      r_bound <= w_boundary;
      if (w_boundary) begin
        if (load_i) begin
          r_active <= data_i;
          r_shadow <= data_i;
        end else if (r_pending) begin
          r_active <= r_shadow;
        end
        r_pending <= 1'b0;
      end else if (load_i) begin
        r_shadow  <= data_i;
        r_pending <= 1'b1;
      end
    end
  end

  // Nibble of the digit currently being scanned
  always_comb begin
    w_nib = 4'd0;
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib = r_active[4*k +: 4];
      end
    end
  end

  // w_lz[k]: digit k and every digit above it are zero; units digit always shown
  always_comb begin
    logic v_run;
    v_run = 1'b1;
    w_lz  = '0;
    for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
      v_run   = v_run && (r_active[4*k +: 4] == 4'd0);
      w_lz[k] = v_run;
    end
    w_lz[0] = 1'b0;
  end

  assign w_onehot = N_DIGITS'(1) << r_idx;
  assign w_blank  = blank_lz_i && (|(w_lz & w_onehot));
  assign w_an     = w_blank ? '1 : ~w_onehot;
  assign w_seg    = w_blank ? 7'b1111111 : decode_seg(w_nib);

  // Registered display outputs; frame_o lines up with the first new digit-0 slot
  always_ff @(posedge clk) begin
    if (rst) begin
      an_o    <= '1;
      seg_o   <= 7'b1111111;
      frame_o <= 1'b0;
    end else begin
      an_o    <= w_an;
      seg_o   <= w_seg;
      frame_o <= r_bound;
    end
  end

endmodule

// File: tb/tb_module_display_mux.sv
// Directed bench for module_display_mux with N_DIGITS=4, REFRESH_DIV=4.
module tb_module_display_mux;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_i;
  logic [15:0]   data_i;
  logic          blank_lz_i;
  logic [ND-1:0] an_o;
  logic [6:0]    seg_o;
  logic          frame_o;

  int          n_chk = 0;
  int          n_bad = 0;
  int          kk    = 0;
  logic [15:0] ev    = 16'h0;
  logic        bl    = 1'b0;

  module_display_mux #(.N_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_i),
    .data_i     (data_i),
    .blank_lz_i (blank_lz_i),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .frame_o    (frame_o)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s kk=%0d got=%h exp=%h", tag, kk, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    kk++;
  endtask

  // Expected outputs for the slot that the last edge produced
  task automatic check_slot();
    int          d;
    logic [15:0] up;
    logic [3:0]  nib;
    logic        blk;
    logic [3:0]  ea;
    logic [6:0]  es;
    d   = ((kk - 1) / 4) % 4;
    up  = ev >> (4 * d);
    nib = up[3:0];
    blk = bl && (d != 0) && (up == 16'h0);
    ea  = blk ? 4'hF : ~(4'b0001 << d);
    es  = blk ? 7'h7F : seg_of(nib);
    chk("an", 32'(an_o), 32'(ea));
    chk("seg", 32'(seg_o), 32'(es));
    chk("frame", 32'(frame_o), 32'((kk > 1) && (kk % 16 == 1)));
  endtask

  // One frame (or len slots of it); loads at positions ta/tb, nxt is expected next frame content
  task automatic frame(input logic b, input int ta, input logic [15:0] da,
                       input int tb, input logic [15:0] db,
                       input logic [15:0] nxt, input int len);
    bl         = b;
    blank_lz_i = b;
    for (int p = 0; p < len; p++) begin
      load_i = (p == ta) || (p == tb);
      data_i = (p == ta) ? da : ((p == tb) ? db : 16'h0);
      tick();
      check_slot();
    end
    load_i = 1'b0;
    data_i = 16'h0;
    if (len == 16) ev = nxt;
  endtask

  initial begin
    rst        = 1'b1;
    load_i     = 1'b0;
    data_i     = 16'h0;
    blank_lz_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_an", 32'(an_o), 32'h0000_000F);
      chk("rst_seg", 32'(seg_o), 32'h0000_007F);
      chk("rst_frame", 32'(frame_o), 32'h0);
    end
    rst = 1'b0;
    kk  = 0;
    ev  = 16'h0;

    frame(1'b0, 5, 16'h1234, -1, 16'h0, 16'h1234, 16);
    frame(1'b0, 2, 16'h1111, 9, 16'h5678, 16'h5678, 16);
    frame(1'b0, 15, 16'h0009, -1, 16'h0, 16'h0009, 16);
    frame(1'b1, 3, 16'h000A, -1, 16'h0, 16'h000A, 16);
    frame(1'b0, 0, 16'h0000, -1, 16'h0, 16'h0000, 16);
    frame(1'b1, 1, 16'h4321, -1, 16'h0, 16'h4321, 16);

    // Pending load, then reset during digit 2; load during reset must be ignored
    frame(1'b0, 3, 16'h9999, -1, 16'h0, 16'h0, 10);
    rst    = 1'b1;
    load_i = 1'b1;
    data_i = 16'h8888;
    tick();
    chk("mid_rst_an", 32'(an_o), 32'h0000_000F);
    chk("mid_rst_seg", 32'(seg_o), 32'h0000_007F);
    chk("mid_rst_frame", 32'(frame_o), 32'h0);
    rst    = 1'b0;
    load_i = 1'b0;
    data_i = 16'h0;
    kk     = 0;
    ev     = 16'h0;
    frame(1'b0, -1, 16'h0, -1, 16'h0, 16'h0, 16);
    frame(1'b0, -1, 16'h0, -1, 16'h0, 16'h0, 16);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
